ipg_tx_scheduler: RTL and testbench

Two-source frame arbiter that sits in front of the `tx_axis` port of `ipg_mac_phy_10g` and shares that single 64-bit MAC transmit stream between two AXI-stream frame producers. Each producer supplies its own inter-frame gap setting. Arbitration is round-robin and frame-atomic. The granted source's gap value is latched onto `ifg_delay` for the duration of its frame. An optional watchdog aborts frames whose source starves mid-frame, so that a stalled source cannot wedge the MAC.

---
 rtl/ipg_tx_scheduler.sv | 177 +++++++++++++++++
 tb/tb_ipg_tx_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipg_tx_scheduler.sv
// Round-robin, frame-atomic arbiter sharing one MAC tx stream between two AXI-stream sources.
// Define IPG_TX_SCHEDULER_WATCHDOG_EN to add the mid-frame starvation watchdog (ABORT/DRAIN).
module ipg_tx_scheduler #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned DEFAULT_IFG = 12,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tuser,
  output logic                  s0_axis_tready,
  input  logic [7:0]            s0_ifg,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tuser,
  output logic                  s1_axis_tready,
  input  logic [7:0]            s1_ifg,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [7:0]            ifg_delay,
  output logic [1:0]            grant,
  output logic [7:0]            abort_count
);

  typedef enum logic [1:0] {StIdle, StBusy, StAbort, StDrain} state_e;

  localparam logic [7:0] DefaultIfg = 8'(DEFAULT_IFG);

  state_e                r_state;
  state_e                w_state_next;
  logic [1:0]            r_grant;
  logic                  r_last;
  logic [7:0]            r_ifg;

  logic                  w_sel;
  logic [DATA_WIDTH-1:0] w_src_tdata;
  logic [KEEP_WIDTH-1:0] w_src_tkeep;
  logic                  w_src_tvalid;
  logic                  w_src_tlast;
  logic                  w_src_tuser;
  logic                  w_req_any;
  logic                  w_pick;
  logic                  w_grant_now;
  logic                  w_fire;
  logic                  w_stall_hit;

  assign w_sel        = r_grant[1];
  assign w_src_tdata  = w_sel ? s1_axis_tdata  : s0_axis_tdata;
  assign w_src_tkeep  = w_sel ? s1_axis_tkeep  : s0_axis_tkeep;
  assign w_src_tvalid = w_sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_src_tlast  = w_sel ? s1_axis_tlast  : s0_axis_tlast;
  assign w_src_tuser  = w_sel ? s1_axis_tuser  : s0_axis_tuser;

  // On a tie the source that did not go last wins.
  assign w_req_any   = s0_axis_tvalid | s1_axis_tvalid;
  assign w_pick      = (s0_axis_tvalid & s1_axis_tvalid) ? ~r_last : s1_axis_tvalid;
  assign w_grant_now = (r_state == StIdle) & w_req_any;
  assign w_fire      = (r_state == StBusy) & w_src_tvalid & m_axis_tready;

`ifdef IPG_TX_SCHEDULER_WATCHDOG_EN
  localparam logic [7:0] StallLimit = 8'(STALL_LIMIT);

  logic [7:0] r_stall;
  logic [7:0] r_abort_cnt;

  assign w_stall_hit = (r_state == StBusy) & ~w_src_tvalid & (r_stall == StallLimit);

  // Only source starvation counts; a MAC stall with tvalid high holds the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall     <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_grant_now || w_fire) begin
        r_stall <= '0;
      end else if (r_state == StBusy && !w_src_tvalid) begin
        r_stall <= r_stall + 8'd1;
      end
      if (w_stall_hit && r_abort_cnt != 8'hff) begin
        r_abort_cnt <= r_abort_cnt + 8'd1;
      end
    end
  end

  assign abort_count = r_abort_cnt;
`else
  logic w_unused_stall_limit;

  assign w_stall_hit          = 1'b0;
  assign w_unused_stall_limit = ^8'(STALL_LIMIT);
  assign abort_count          = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_last  <= 1'b1;
      r_ifg   <= DefaultIfg;
    end else begin
      r_state <= w_state_next;
      if (w_grant_now) begin
        r_grant <= w_pick ? 2'b10 : 2'b01;
        r_last  <= w_pick;
        r_ifg   <= w_pick ? s1_ifg : s0_ifg;
      end else if (w_state_next == StIdle) begin
        r_grant <= '0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_req_any) w_state_next = StBusy;
      StBusy: begin
        if (w_fire && w_src_tlast) w_state_next = StIdle;
        else if (w_stall_hit)      w_state_next = StAbort;
      end
`ifdef IPG_TX_SCHEDULER_WATCHDOG_EN
      StAbort: if (m_axis_tready) w_state_next = StDrain;
      StDrain: if (w_src_tvalid && w_src_tlast) w_state_next = StIdle;
`endif
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    unique case (r_state)
      StBusy: begin
        m_axis_tdata   = w_src_tdata;
        m_axis_tkeep   = w_src_tkeep;
        m_axis_tvalid  = w_src_tvalid;
        m_axis_tlast   = w_src_tlast;
        m_axis_tuser   = w_src_tuser;
        s0_axis_tready = ~w_sel & m_axis_tready;
        s1_axis_tready = w_sel & m_axis_tready;
      end
`ifdef IPG_TX_SCHEDULER_WATCHDOG_EN
      // Error beat terminates the truncated frame at the MAC.
      StAbort: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        m_axis_tkeep  = KEEP_WIDTH'(1);
      end
      StDrain: begin
        s0_axis_tready = ~w_sel;
        s1_axis_tready = w_sel;
      end
`endif
      default: ;
    endcase
  end

  assign ifg_delay = r_ifg;
  assign grant     = r_grant;

endmodule

// File: tb/tb_ipg_tx_scheduler.sv
// Bench for ipg_tx_scheduler: per-cycle reference model plus directed frame scenarios.
module tb_ipg_tx_scheduler;

  localparam int unsigned Dw    = 64;
  localparam int unsigned Kw    = 8;
  localparam int unsigned Limit = 4;
`ifdef IPG_TX_SCHEDULER_WATCHDOG_EN
  localparam bit         Wd        = 1'b1;
  localparam logic [7:0] ExpAborts = 8'd1;
`else
  localparam bit         Wd        = 1'b0;
  localparam logic [7:0] ExpAborts = 8'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [Dw-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [Kw-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tuser, s0_axis_tready;
  logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tuser, s1_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic [7:0]    s0_ifg, s1_ifg, ifg_delay, abort_count;
  logic [1:0]    grant;

  ipg_tx_scheduler #(
    .DATA_WIDTH (Dw),
    .KEEP_WIDTH (Kw),
    .DEFAULT_IFG(12),
    .STALL_LIMIT(Limit)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s0_axis_tdata (s0_axis_tdata),
    .s0_axis_tkeep (s0_axis_tkeep),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast (s0_axis_tlast),
    .s0_axis_tuser (s0_axis_tuser),
    .s0_axis_tready(s0_axis_tready),
    .s0_ifg        (s0_ifg),
    .s1_axis_tdata (s1_axis_tdata),
    .s1_axis_tkeep (s1_axis_tkeep),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast (s1_axis_tlast),
    .s1_axis_tuser (s1_axis_tuser),
    .s1_axis_tready(s1_axis_tready),
    .s1_ifg        (s1_ifg),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .ifg_delay     (ifg_delay),
    .grant         (grant),
    .abort_count   (abort_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source stimulus: v=0 entries are one-cycle bubbles inside a frame.
  typedef struct {logic v; logic last; logic [63:0] d;} item_t;
  item_t q0[$];
  item_t q1[$];

  task automatic push(input int src, input bit v, input bit last, input logic [63:0] d);
    item_t it;
    it.v = v; it.last = last; it.d = d;
    if (src == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  initial begin
    bit hs;
    s0_axis_tvalid = 0; s0_axis_tlast = 0; s0_axis_tdata = '0;
    s0_axis_tuser = 0; s0_axis_tkeep = 8'hff;
    forever begin
      @(negedge clk);
      hs = s0_axis_tvalid && s0_axis_tready;
      @(posedge clk);
      #1;
      if (q0.size() > 0 && (!q0[0].v || hs)) void'(q0.pop_front());
      if (q0.size() > 0) begin
        s0_axis_tvalid = q0[0].v; s0_axis_tlast = q0[0].last; s0_axis_tdata = q0[0].d;
      end else begin
        s0_axis_tvalid = 0; s0_axis_tlast = 0; s0_axis_tdata = '0;
      end
    end
  end

  initial begin
    bit hs;
    s1_axis_tvalid = 0; s1_axis_tlast = 0; s1_axis_tdata = '0;
    s1_axis_tuser = 0; s1_axis_tkeep = 8'hff;
    forever begin
      @(negedge clk);
      hs = s1_axis_tvalid && s1_axis_tready;
      @(posedge clk);
      #1;
      if (q1.size() > 0 && (!q1[0].v || hs)) void'(q1.pop_front());
      if (q1.size() > 0) begin
        s1_axis_tvalid = q1[0].v; s1_axis_tlast = q1[0].last; s1_axis_tdata = q1[0].d;
      end else begin
        s1_axis_tvalid = 0; s1_axis_tlast = 0; s1_axis_tdata = '0;
      end
    end
  end

  // Beats accepted by the MAC, with the cycle and gap setting at the moment of transfer.
  typedef struct {int cyc; logic [63:0] d; logic last; logic user; logic [7:0] keep;
                  logic [7:0] ifg;} beat_t;
  beat_t got[$];

  always @(negedge clk) begin
    beat_t b;
    if (m_axis_tvalid && m_axis_tready) begin
      b.cyc = cyc; b.d = m_axis_tdata; b.last = m_axis_tlast; b.user = m_axis_tuser;
      b.keep = m_axis_tkeep; b.ifg = ifg_delay;
      got.push_back(b);
    end
  end

  // Reference model: 0 idle, 1 forwarding, 2 error beat, 3 discarding rest of frame.
  int         md_mode = 0;
  int         md_src  = 0;
  bit         md_last = 1'b1;
  logic [7:0] md_ifg  = 8'd12;
  int         md_starve = 0;
  int         md_aborts = 0;
  bit         md_ok = 1'b0;

  always @(negedge clk) begin
    logic [10:0] exp_ctl;
    logic [63:0] exp_data;
    logic [1:0]  exp_rdy;
    logic        sv, sl;
    sv = (md_src == 1) ? s1_axis_tvalid : s0_axis_tvalid;
    sl = (md_src == 1) ? s1_axis_tlast : s0_axis_tlast;
    if (md_ok) begin
      exp_ctl = '0; exp_data = '0; exp_rdy = '0;
      if (md_mode == 1) begin
        exp_ctl  = (md_src == 1) ? {s1_axis_tvalid, s1_axis_tlast, s1_axis_tuser, s1_axis_tkeep}
                                 : {s0_axis_tvalid, s0_axis_tlast, s0_axis_tuser, s0_axis_tkeep};
        exp_data = (md_src == 1) ? s1_axis_tdata : s0_axis_tdata;
        exp_rdy  = (md_src == 1) ? {m_axis_tready, 1'b0} : {1'b0, m_axis_tready};
      end else if (md_mode == 2) begin
        exp_ctl = {1'b1, 1'b1, 1'b1, 8'h01};
      end else if (md_mode == 3) begin
        exp_rdy = (md_src == 1) ? 2'b10 : 2'b01;
      end
      chk("model_grant", grant, (md_mode == 0) ? 2'b00 : ((md_src == 1) ? 2'b10 : 2'b01));
      chk("model_ifg", ifg_delay, md_ifg);
      chk("model_aborts", abort_count, md_aborts);
      chk("model_src_ready", {s1_axis_tready, s0_axis_tready}, exp_rdy);
      if (md_mode == 3) begin
        chk("model_drain_valid", m_axis_tvalid, 0);
      end else begin
        chk("model_m_ctl", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep}, exp_ctl);
        chk("model_m_data", m_axis_tdata, exp_data);
      end
    end
    if (rst) begin
      md_mode = 0; md_src = 0; md_last = 1'b1; md_ifg = 8'd12;
      md_starve = 0; md_aborts = 0; md_ok = 1'b1;
    end else if (md_ok) begin
      case (md_mode)
        0: if (s0_axis_tvalid || s1_axis_tvalid) begin
          md_src    = (s0_axis_tvalid && s1_axis_tvalid) ? int'(!md_last) : int'(s1_axis_tvalid);
          md_last   = (md_src == 1);
          md_ifg    = (md_src == 1) ? s1_ifg : s0_ifg;
          md_starve = 0;
          md_mode   = 1;
        end
        1: if (sv && m_axis_tready) begin
          md_starve = 0;
          if (sl) md_mode = 0;
        end else if (!sv) begin
          if (Wd && md_starve == Limit) begin
            md_mode = 2;
            if (md_aborts < 255) md_aborts++;
          end else begin
            md_starve++;
          end
        end
        2: if (m_axis_tready) md_mode = 3;
        3: if (sv && sl) md_mode = 0;
        default: md_mode = 0;
      endcase
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_timeout"}, q0.size() + q1.size(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] e2 [4];
    e2[0] = 64'hA1; e2[1] = 64'hA2; e2[2] = 64'hB1; e2[3] = 64'hB2;
    rst = 1'b1; m_axis_tready = 1'b1; s0_ifg = 8'd12; s1_ifg = 8'd20;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_ifg", ifg_delay, 12);
    chk("rst_aborts", abort_count, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);

    // Single source, 8-beat frame
    got.delete();
    for (int i = 1; i <= 8; i++) push(0, 1, i == 8, 64'(i));
    n = 0;
    do @(negedge clk); while (!s0_axis_tvalid && ++n < 20);
    chk("t1_grant_at_valid", grant, 2'b00);
    @(posedge clk);
    #2;
    chk("t1_grant", grant, 2'b01);
    chk("t1_ifg", ifg_delay, 12);
    wait_idle("t1");
    chk("t1_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        chk("t1_data", got[i].d, 64'(i + 1));
        chk("t1_last", got[i].last, i == 7);
      end
    end
    chk("t1_grant_end", grant, 2'b00);

    // Tie after reset, then repeated tie
    do_reset();
    got.delete();
    push(0, 1, 0, 64'hA1); push(0, 1, 1, 64'hA2);
    push(1, 1, 0, 64'hB1); push(1, 1, 1, 64'hB2);
    wait_idle("t2");
    chk("t2_count", got.size(), 4);
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", got[i].d, e2[i]);
      chk("t2_dead_gap", got[2].cyc - got[1].cyc, 2);
      chk("t2_ifg_s0", got[0].ifg, 12);
      chk("t2_ifg_s1", got[2].ifg, 20);
    end
    got.delete();
    push(0, 1, 0, 64'hA1); push(0, 1, 1, 64'hA2);
    push(1, 1, 0, 64'hB1); push(1, 1, 1, 64'hB2);
    wait_idle("t2b");
    chk("t2b_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t2b_first", got[0].d, 64'hA1);
      chk("t2b_ifg_first", got[0].ifg, 12);
    end

    // MAC backpressure mid-frame
    got.delete();
    for (int i = 0; i < 8; i++) push(0, 1, i == 7, 64'h10 + 64'(i));
    repeat (4) @(posedge clk);
    #2;
    m_axis_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_ready", s0_axis_tready, 0);
    end
    @(posedge clk);
    #2;
    m_axis_tready = 1'b1;
    wait_idle("t3");
    chk("t3_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk("t3_data", got[i].d, 64'h10 + 64'(i));
    end
    chk("t3_aborts", abort_count, 0);

    // Source starves 6 cycles mid-frame
    do_reset();
    got.delete();
    for (int i = 1; i <= 3; i++) push(1, 1, 0, 64'hC0 + 64'(i));
    repeat (6) push(1, 0, 0, 64'h0);
    push(1, 1, 0, 64'hC4); push(1, 1, 1, 64'hC5);
    wait_idle("t4");
`ifdef IPG_TX_SCHEDULER_WATCHDOG_EN
    chk("t4_count", got.size(), 4);
    if (got.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("t4_data", got[i].d, 64'hC1 + 64'(i));
      chk("t4_err_beat", {got[3].last, got[3].user, got[3].keep}, {1'b1, 1'b1, 8'h01});
      chk("t4_err_data", got[3].d, 0);
      chk("t4_err_time", got[3].cyc - got[2].cyc, 6);
    end
    chk("t4_aborts", abort_count, 1);
`else
    chk("t4_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk("t4_data", got[i].d, 64'hC1 + 64'(i));
    end
    chk("t4_aborts", abort_count, 0);
`endif
    chk("t4_grant_end", grant, 2'b00);

    // tvalid returns exactly on the limit cycle
    got.delete();
    for (int i = 1; i <= 3; i++) push(1, 1, 0, 64'hD0 + 64'(i));
    repeat (Limit) push(1, 0, 0, 64'h0);
    push(1, 1, 0, 64'hD4); push(1, 1, 1, 64'hD5);
    wait_idle("t5");
    chk("t5_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        chk("t5_data", got[i].d, 64'hD1 + 64'(i));
        chk("t5_flags", {got[i].last, got[i].user}, {i == 4, 1'b0});
      end
    end
    if (got.size() == 5) chk("t5_resume_time", got[3].cyc - got[2].cyc, Limit + 1);
    chk("t5_aborts", abort_count, ExpAborts);

    // Reset during beat 3
    s0_ifg = 8'd7;
    got.delete();
    for (int i = 1; i <= 8; i++) push(0, 1, i == 8, 64'h20 + 64'(i));
    n = 0;
    do @(negedge clk);
    while (!(s0_axis_tvalid && s0_axis_tready && s0_axis_tdata == 64'h22) && ++n < 30);
    chk("t6_ifg_before", ifg_delay, 7);
    @(posedge clk);
    #2;
    do_reset();
    chk("t6_grant", grant, 2'b00);
    chk("t6_mvalid", m_axis_tvalid, 0);
    chk("t6_ready", {s1_axis_tready, s0_axis_tready}, 2'b00);
    chk("t6_ifg", ifg_delay, 12);
    chk("t6_aborts", abort_count, 0);

    // Single-beat frame after reset
    s1_ifg = 8'd9;
    got.delete();
    push(1, 1, 1, 64'hF1);
    wait_idle("t7");
    chk("t7_count", got.size(), 1);
    if (got.size() == 1) begin
      chk("t7_beat", {got[0].d, got[0].last}, {64'hF1, 1'b1});
      chk("t7_ifg", got[0].ifg, 9);
    end
    chk("t7_grant_end", grant, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
